// File: rtl/mac_tile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_tile_pkg
// Description : Shared constants for the mixed-precision MAC tile:
//               instruction bit positions, precision-mode encodings and
//               the number of weight-load beats each mode needs.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_tile_pkg;

    // Bit positions inside the 3-bit instruction word {mode, exec, load}
    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;
    localparam int INST_MODE = 2;

    // Precision modes
    localparam logic MODE_LP = 1'b0;  // independent bw-bit lanes
    localparam logic MODE_HP = 1'b1;  // lane pairs fused to 2bw-bit

    // Weight-load beats needed to fill a bank in each mode
    localparam int LP_BEATS = 2;
    localparam int HP_BEATS = 1;

    // True when a beat at position ptr completes the load for this mode
    function automatic logic is_last_beat(input logic mode, input logic ptr);
        int beats;
        beats = (mode == MODE_HP) ? HP_BEATS : LP_BEATS;
        return (int'(ptr) == beats - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane_pair.sv
`default_nettype none
// ============================================================================
// Module      : mac_lane_pair
// Description : Combinational next-psum logic for two adjacent lanes.
//               Low precision: two independent signed-weight x unsigned-
//               activation MACs. High precision: one fused MAC with the
//               activations and psums concatenated pairwise.
// Ports       : i_a0/i_a1  activations (lane 2j, 2j+1)
//               i_n0/i_n1  incoming psums
//               i_w0/i_w1  per-lane weights (low precision)
//               i_wf       fused weight (high precision)
//               i_mode     precision mode
//               o_n0/o_n1  next psums
// Revision    : 1.0 - initial release
// ============================================================================
module mac_lane_pair
    import mac_tile_pkg::*;
#(
    parameter int BW      = 2,
    parameter int PSUM_BW = 9
) (
    input  logic [BW-1:0]      i_a0,
    input  logic [BW-1:0]      i_a1,
    input  logic [PSUM_BW-1:0] i_n0,
    input  logic [PSUM_BW-1:0] i_n1,
    input  logic [2*BW-1:0]    i_w0,
    input  logic [2*BW-1:0]    i_w1,
    input  logic [2*BW-1:0]    i_wf,
    input  logic               i_mode,
    output logic [PSUM_BW-1:0] o_n0,
    output logic [PSUM_BW-1:0] o_n1
);

    // Working width wide enough for the fused product and the fused psum,
    // so every intermediate is exact before the final modular truncation.
    localparam int c_XW = (2*PSUM_BW > 6*BW+1) ? 2*PSUM_BW : 6*BW+1;

    logic signed [c_XW-1:0]      w_w0_x, w_w1_x, w_wf_x;
    logic signed [c_XW-1:0]      w_a0_x, w_a1_x, w_af_x;
    logic signed [c_XW-1:0]      w_n0_x, w_n1_x, w_pf_x;
    logic        [PSUM_BW-1:0]   w_lp0, w_lp1;
    logic        [2*PSUM_BW-1:0] w_hp;

    // Weights and psums sign-extend; activations zero-extend
    assign w_w0_x = c_XW'($signed(i_w0));
    assign w_w1_x = c_XW'($signed(i_w1));
    assign w_wf_x = c_XW'($signed(i_wf));
    assign w_a0_x = c_XW'({1'b0, i_a0});
    assign w_a1_x = c_XW'({1'b0, i_a1});
    assign w_af_x = c_XW'({1'b0, i_a1, i_a0});
    assign w_n0_x = c_XW'($signed(i_n0));
    assign w_n1_x = c_XW'($signed(i_n1));
    assign w_pf_x = c_XW'($signed({i_n1, i_n0}));

    assign w_lp0 = PSUM_BW'(w_n0_x + w_w0_x * w_a0_x);
    assign w_lp1 = PSUM_BW'(w_n1_x + w_w1_x * w_a1_x);
    assign w_hp  = (2*PSUM_BW)'(w_pf_x + w_wf_x * w_af_x);

    assign o_n0 = (i_mode == MODE_HP) ? w_hp[PSUM_BW-1:0]         : w_lp0;
    assign o_n1 = (i_mode == MODE_HP) ? w_hp[2*PSUM_BW-1:PSUM_BW] : w_lp1;

endmodule
`default_nettype wire

// File: rtl/mac_tile_mp.sv
`default_nettype none
// ============================================================================
// Module      : mac_tile_mp
// Description : Mixed-precision MAC tile with double-buffered weights.
//               LANES bw-bit lanes (mode 0) or LANES/2 fused 2bw-bit lanes
//               (mode 1). Weights stream into the shadow bank while the
//               active bank keeps executing; the banks swap on the final
//               load beat.
// Ports       : clk, reset     clock, synchronous active-high reset
//               in_w           activations / weight beats from west
//               in_n           psums from north
//               inst_w         {mode, exec, load}
//               out_s          registered psums to south
//               out_e          registered activations to east
//               inst_e         inst_w delayed one cycle
//               wload_done     pulse: new weight bank active this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mac_tile_mp
    import mac_tile_pkg::*;
#(
    parameter int BW      = 2,
    parameter int PSUM_BW = 9,
    parameter int LANES   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANES*BW-1:0]      in_w,
    input  logic [LANES*PSUM_BW-1:0] in_n,
    input  logic [2:0]               inst_w,
    output logic [LANES*PSUM_BW-1:0] out_s,
    output logic [LANES*BW-1:0]      out_e,
    output logic [2:0]               inst_e,
    output logic                     wload_done
);

    localparam int c_HALF = LANES / 2;

    logic [2*BW-1:0]          r_bank [2][LANES];
    logic                     r_active_sel;
    logic                     r_ptr;
    logic                     r_load_mode;
    logic [LANES*PSUM_BW-1:0] r_out_s;
    logic [LANES*BW-1:0]      r_out_e;
    logic [2:0]               r_inst_e;
    logic                     r_wload_done;

    logic                     w_load, w_exec, w_mode;
    logic                     w_eff_ptr, w_last, w_shadow;
    logic [LANES-1:0]         w_we;
    logic [2*BW-1:0]          w_wdata [LANES];
    logic [LANES*PSUM_BW-1:0] w_next_s;

    assign w_load   = inst_w[INST_LOAD];
    assign w_exec   = inst_w[INST_EXEC];
    assign w_mode   = inst_w[INST_MODE];
    assign w_shadow = ~r_active_sel;

    // A mode change during a partial load restarts the pointer; the beat
    // arriving with the new mode is treated as its beat 0.
    assign w_eff_ptr = (r_ptr != 1'b0 && w_mode != r_load_mode) ? 1'b0 : r_ptr;
    assign w_last    = w_load && is_last_beat(w_mode, w_eff_ptr);

    // Slot s takes weight j = s % HALF of the beat whose index is s / HALF.
    // Weight j is {lane 2j+1, lane 2j}, i.e. the contiguous 2bw slice.
    for (genvar s = 0; s < LANES; s++) begin : g_slot
        assign w_we[s]    = w_load && (int'(w_eff_ptr) == s / c_HALF);
        assign w_wdata[s] = in_w[(2*(s % c_HALF))*BW +: 2*BW];
    end

    for (genvar j = 0; j < c_HALF; j++) begin : g_pair
        mac_lane_pair #(
            .BW      (BW),
            .PSUM_BW (PSUM_BW)
        ) u_pair (
            .i_a0   (in_w[(2*j)*BW +: BW]),
            .i_a1   (in_w[(2*j+1)*BW +: BW]),
            .i_n0   (in_n[(2*j)*PSUM_BW +: PSUM_BW]),
            .i_n1   (in_n[(2*j+1)*PSUM_BW +: PSUM_BW]),
            .i_w0   (r_bank[r_active_sel][2*j]),
            .i_w1   (r_bank[r_active_sel][2*j+1]),
            .i_wf   (r_bank[r_active_sel][j]),
            .i_mode (w_mode),
            .o_n0   (w_next_s[(2*j)*PSUM_BW +: PSUM_BW]),
            .o_n1   (w_next_s[(2*j+1)*PSUM_BW +: PSUM_BW])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < LANES; s++) begin
                    r_bank[b][s] <= '0;
                end
            end
            r_active_sel <= 1'b0;
            r_ptr        <= 1'b0;
            r_load_mode  <= MODE_LP;
            r_out_s      <= '0;
            r_out_e      <= '0;
            r_inst_e     <= '0;
            r_wload_done <= 1'b0;
        end else begin
            r_inst_e <= inst_w;
            if (w_exec || w_load) begin
                r_out_e <= in_w;
            end
            // Exec reads the pre-swap active bank even on the final beat
            if (w_exec) begin
                r_out_s <= w_next_s;
            end
            for (int s = 0; s < LANES; s++) begin
                if (w_we[s]) begin
                    r_bank[w_shadow][s] <= w_wdata[s];
                end
            end
            if (w_load) begin
                r_load_mode <= w_mode;
                r_ptr       <= w_last ? 1'b0 : w_eff_ptr + 1'b1;
            end else begin
                r_ptr <= w_eff_ptr;
            end
            if (w_last) begin
                r_active_sel <= ~r_active_sel;
            end
            r_wload_done <= w_last;
        end
    end

    assign out_s      = r_out_s;
    assign out_e      = r_out_e;
    assign inst_e     = r_inst_e;
    assign wload_done = r_wload_done;

endmodule
`default_nettype wire

// File: tb/tb_mac_tile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_tile_mp
// Description : Self-checking bench for mac_tile_mp (LANES=4, bw=2,
//               psum_bw=9). Directed scenarios plus random traffic, all
//               compared against an integer reference model of the tile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_tile_mp;

    localparam int BW      = 2;
    localparam int PSUM_BW = 9;
    localparam int LANES   = 4;
    localparam int HALF    = LANES / 2;

    typedef logic [LANES*BW-1:0]      aw_t;
    typedef logic [LANES*PSUM_BW-1:0] ps_t;

    logic       clk = 1'b0;
    logic       reset;
    aw_t        in_w;
    ps_t        in_n;
    logic [2:0] inst_w;
    ps_t        out_s;
    aw_t        out_e;
    logic [2:0] inst_e;
    logic       wload_done;

    always #5 clk = ~clk;

    mac_tile_mp #(
        .BW      (BW),
        .PSUM_BW (PSUM_BW),
        .LANES   (LANES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_w       (in_w),
        .in_n       (in_n),
        .inst_w     (inst_w),
        .out_s      (out_s),
        .out_e      (out_e),
        .inst_e     (inst_e),
        .wload_done (wload_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------
    longint m_bank [2][LANES];
    int     m_sel, m_ptr, m_lmode, m_wdone, m_inst_e;
    longint m_out_s [LANES];
    aw_t    m_out_e;

    function automatic longint lane_a(input aw_t v, input int k);
        return longint'(v[k*BW +: BW]);
    endfunction

    function automatic longint lane_n(input ps_t v, input int k);
        return longint'(v[k*PSUM_BW +: PSUM_BW]);
    endfunction

    function automatic longint sext(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (v >= half) ? v - 2*half : v;
    endfunction

    task automatic model_step(input bit rst, input logic [2:0] inst, input aw_t w, input ps_t n);
        int ld, ex, md, p, beats;
        longint a, ps, r;
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int s = 0; s < LANES; s++) m_bank[b][s] = 0;
            for (int k = 0; k < LANES; k++) m_out_s[k] = 0;
            m_sel = 0; m_ptr = 0; m_lmode = 0; m_wdone = 0; m_inst_e = 0; m_out_e = '0;
            return;
        end
        ld = int'(inst[0]); ex = int'(inst[1]); md = int'(inst[2]);
        m_inst_e = int'(inst);
        if (ex != 0) begin
            if (md == 0) begin
                for (int k = 0; k < LANES; k++) begin
                    r = sext(lane_n(n, k), PSUM_BW) + m_bank[m_sel][k] * lane_a(w, k);
                    m_out_s[k] = r & ((longint'(1) << PSUM_BW) - 1);
                end
            end else begin
                for (int j = 0; j < HALF; j++) begin
                    a  = lane_a(w, 2*j+1) * (longint'(1) << BW) + lane_a(w, 2*j);
                    ps = sext(lane_n(n, 2*j+1), PSUM_BW) * (longint'(1) << PSUM_BW) + lane_n(n, 2*j);
                    r  = (ps + m_bank[m_sel][j] * a) & ((longint'(1) << (2*PSUM_BW)) - 1);
                    m_out_s[2*j]   = r & ((longint'(1) << PSUM_BW) - 1);
                    m_out_s[2*j+1] = r >> PSUM_BW;
                end
            end
        end
        if (ex != 0 || ld != 0) m_out_e = w;
        p = (m_ptr != 0 && md != m_lmode) ? 0 : m_ptr;
        if (ld != 0) begin
            beats = (md != 0) ? 1 : 2;
            for (int j = 0; j < HALF; j++)
                m_bank[1-m_sel][p*HALF+j] =
                    sext(lane_a(w, 2*j+1) * (longint'(1) << BW) + lane_a(w, 2*j), 2*BW);
            m_lmode = md;
            if (p == beats - 1) begin
                m_sel = 1 - m_sel; m_ptr = 0; m_wdone = 1;
            end else begin
                m_ptr = p + 1; m_wdone = 0;
            end
        end else begin
            m_ptr = p; m_wdone = 0;
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare after it
    task automatic cyc(input bit rst, input logic [2:0] inst, input aw_t w, input ps_t n);
        ps_t e;
        reset = rst; inst_w = inst; in_w = w; in_n = n;
        @(posedge clk);
        model_step(rst, inst, w, n);
        #1;
        e = '0;
        for (int k = 0; k < LANES; k++) e[k*PSUM_BW +: PSUM_BW] = PSUM_BW'(m_out_s[k]);
        check("out_s", longint'(out_s), longint'(e));
        check("out_e", longint'(out_e), longint'(m_out_e));
        check("inst_e", longint'(inst_e), longint'(m_inst_e));
        check("wload_done", longint'(wload_done), longint'(m_wdone));
    endtask

    function automatic longint out_lane(input int k);
        return longint'(out_s[k*PSUM_BW +: PSUM_BW]);
    endfunction

    function automatic ps_t rand_ps();
        return ps_t'({$urandom(), $urandom()});
    endfunction

    initial begin
        ps_t n;
        reset = 1'b1; inst_w = '0; in_w = '0; in_n = '0;
        cyc(1, 3'b000, '0, '0);
        cyc(1, 3'b000, '0, '0);
        check("reset_out_s", longint'(out_s), 0);

        // exec before any load: weights are zero, psums pass through
        n = rand_ps();
        cyc(0, 3'b010, 8'hB4, n);
        check("preload_pass", longint'(out_s), longint'(n));

        // mode-0 load: W0=-7, W1=7 (beat 0), W2=-7, W3=7 (beat 1)
        cyc(0, 3'b001, 8'b01_11_10_01, '0);
        check("lp_no_early_done", longint'(wload_done), 0);
        cyc(0, 3'b001, 8'b01_11_10_01, '0);
        check("lp_done_pulse", longint'(wload_done), 1);
        cyc(0, 3'b010, 8'hAA, '0);
        check("lp_lane0", out_lane(0), 'h1F2);
        check("lp_lane1", out_lane(1), 14);
        n = '0; n[0 +: PSUM_BW] = 9'd21; n[PSUM_BW +: PSUM_BW] = 9'd50;
        cyc(0, 3'b010, 8'h03, n);
        check("lp2_lane0", out_lane(0), 0);
        check("lp2_lane1", out_lane(1), 50);

        // mode-1 fused: W=-2, A=7 -> -14 across 18 bits
        cyc(0, 3'b101, 8'b11_10_11_10, '0);
        cyc(0, 3'b110, 8'b01_11_01_11, '0);
        check("hp_lo", out_lane(0), 'h1F2);
        check("hp_hi", out_lane(1), 'h1FF);

        // double buffer: load W=1 while executing on the old bank (W0=-2)
        cyc(0, 3'b011, 8'h11, '0);
        check("db_old0", out_lane(0), 'h1FE);
        cyc(0, 3'b011, 8'h11, '0);
        check("db_old1", out_lane(0), 'h1FE);
        cyc(0, 3'b010, 8'h55, '0);
        check("db_new0", out_lane(0), 1);
        check("db_new1", out_lane(1), 1);

        // mode switch mid-load: mode-0 beat 0 abandoned, mode-1 beat swaps
        cyc(0, 3'b001, 8'h05, '0);
        check("sw_no_swap", longint'(wload_done), 0);
        cyc(0, 3'b101, 8'h03, '0);
        check("sw_swap", longint'(wload_done), 1);
        cyc(0, 3'b110, 8'h02, '0);
        check("sw_r_lo", out_lane(0), 6);
        check("sw_r_hi", out_lane(1), 0);

        // wrap: W0=7, a0=3, n0=-1 -> 20; W0=-8, a0=3, n0=-256 -> 232
        cyc(0, 3'b001, 8'h77, '0);
        cyc(0, 3'b001, 8'h77, '0);
        n = '0; n[0 +: PSUM_BW] = 9'h1FF;
        cyc(0, 3'b010, 8'hFF, n);
        check("wrap_pos", out_lane(0), 20);
        cyc(0, 3'b001, 8'h88, '0);
        cyc(0, 3'b001, 8'h88, '0);
        n = '0; n[0 +: PSUM_BW] = 9'h100;
        cyc(0, 3'b010, 8'hFF, n);
        check("wrap_neg", out_lane(0), 232);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 3'b000, aw_t'($urandom()), rand_ps());
            check("hold_s", out_lane(0), 232);
            check("hold_e", longint'(out_e), 'hFF);
        end

        // reset mid-load discards the partial load
        cyc(0, 3'b001, aw_t'($urandom()), '0);
        cyc(1, 3'b001, aw_t'($urandom()), rand_ps());
        check("rst_out_s", longint'(out_s), 0);
        check("rst_out_e", longint'(out_e), 0);
        n = '0; n[0 +: PSUM_BW] = 9'd33;
        cyc(0, 3'b010, aw_t'($urandom()), n);
        check("rst_exec", out_lane(0), 33);

        // random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 63) == 0), 3'($urandom_range(0, 7)),
                aw_t'($urandom()), rand_ps());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_tile_mp.md
Name: mac_tile_mp

Overview:
Parametrised successor of the 2-lane mac tile. It has LANES activation lanes and two runtime precision modes:
- Mode 0: LANES independent bw-bit MACs.
- Mode 1: lane pairs fused into 2bw-bit MACs.

Weights are double-buffered (shadow/active banks), so a new weight set streams in while execution continues. Tiles chain west→east (activations, instruction) and north→south (psums) inside the array.

Parameters:
bw, 2, activation lane width; weights are 2*bw signed.
psum_bw, 9, per-lane psum width.
LANES, 4, lane count; even, >=2.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_w  in  LANES*bw  activations/weight beats from west; lane k = [k*bw +: bw]
in_n  in  LANES*psum_bw  psums from north; lane k = [k*psum_bw +: psum_bw]
inst_w  in  3  {mode, exec, load}
out_s  out  LANES*psum_bw  psums to south, registered
out_e  out  LANES*bw  activations to east, registered
inst_e  out  3  inst_w delayed one cycle
wload_done  out  1  one-cycle pulse: new weight bank active this cycle

Behaviour:
- Reset (synchronous, clocked by clk): out_s, out_e, inst_e, wload_done = 0; both weight banks = 0; load pointer = 0; active_sel = 0. Reset mid-load discards the partial load.
- inst_e <= inst_w every cycle.
- out_e <= in_w when exec|load; otherwise out_e holds.

Weight load:
- Each load beat forms LANES/2 weights of 2bw bits: weight j = {in_w lane 2j+1, in_w lane 2j}. All weights are written to the shadow bank (~active_sel).
- Mode 0 needs LANES weights, i.e. 2 beats. Beat p writes slots p*(LANES/2)+j.
- Mode 1 needs LANES/2 weights, i.e. 1 beat, written to slots 0..LANES/2-1.
- On the final beat: the shadow write and the active_sel toggle take effect at the same edge; ptr returns to 0; wload_done = 1 the next cycle.
- If mode changes while ptr != 0, ptr is cleared. The current beat counts as beat 0 of the new mode. Slots already written stay in the shadow bank; no swap occurs for the abandoned load.
- Slots not rewritten keep their old shadow content.

Execute (exec=1), using the active bank:
- Mode 0, lane k: out_s[k] <= in_n[k] + sext(W[k]) * zext(a_k).
  - The signed 2bw × unsigned bw product is sign-extended to psum_bw.
  - The sum wraps modulo 2^psum_bw.
- Mode 1, pair j:
  - Activation A = {a_2j+1, a_2j}, unsigned 2bw.
  - Psum P = {in_n[2j+1], in_n[2j]}, signed 2*psum_bw.
  - Result R = P + sext(W[j]) * zext(A), wrapping modulo 2^(2*psum_bw).
  - out_s[2j] <= R low half; out_s[2j+1] <= R high half.
- Latency: 1 cycle from inputs to out_s.
- exec=0: out_s holds its value.

Simultaneous load + exec:
- Legal; exec uses the pre-swap active bank in the same cycle, including the final beat.
- exec in the cycle after the final beat uses the new bank.

Other boundary rules:
- exec before any load: weights are 0, so out_s = in_n.
- Mode may differ between load and exec. Weights are interpreted per the exec mode's slot mapping; there is no error flag.

Decomposition:
- mac_tile_pkg holds:
  - inst bit indices: INST_LOAD=0, INST_EXEC=1, INST_MODE=2;
  - mode constants: MODE_LP=0, MODE_HP=1;
  - load-beat counts per mode.
- One sub-module, mac_lane_pair, is instantiated LANES/2 times:
  - inputs: two activations, two psums, two lane weights, fused weight, mode;
  - output: two next-psums (combinational).
- mac_tile_mp owns the banks, load pointer, swap logic, and output registers.

Test Plan:
(LANES=2, bw=2, psum_bw=9 unless stated.)
- Mode-0 load/exec:
  - Stimulus: load beats in_w={10,01} then {01,11}, so W0=-7, W1=7; then exec a0=2, a1=2, n=0.
  - Required: wload_done pulses after beat 2; out_s0=9'h1F2 (-14), out_s1=9'd14.
  - Next: exec a0=3, a1=0, n0=21, n1=50 → out_s0=0, out_s1=50.
- Mode-1 fused:
  - Stimulus: one load beat in_w lane0=10, lane1=11 (W=-2); then exec lane0=11, lane1=01 (A=7), n=0.
  - Required: out_s0=9'h1F2, out_s1=9'h1FF (-14 across 18 bits).
- Double buffer (active W0=-7, W1=7):
  - Stimulus: two beats with load+exec loading W0=1, W1=1; a0=a1=1, n=0 on every exec.
  - Required: both execs give out_s={7, -7 (9'h1F9)} (out_s1, out_s0); the exec after the swap gives out_s={1, 1}.
- Mode switch mid-load:
  - Stimulus: mode-0 beat 0 (W0=5), then a mode-1 beat (W=3).
  - Required: swap after the mode-1 beat; mode-1 exec with A=2 gives R=6; no swap on the abandoned mode-0 load.
- Wrap and hold:
  - Stimulus: mode 0, W0=7, a0=3, n0=9'h1FF → out_s0=20. W0=-8, a0=3, n0=9'h100 (-256) → -280 wraps to 9'd232.
  - Then exec=0 for 3 cycles → out_s unchanged; out_e unchanged; inst_e follows inst_w.
- Reset mid-load:
  - Stimulus: assert reset after beat 0 of a mode-0 load.
  - Required: all outputs 0 the next cycle; banks 0; subsequent exec with n0=33 gives out_s0=33.
